// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with iterative unsigned multiply/divide and valid/ready handshakes
module seq_alu #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] srcA,
  input  logic [W-1:0] srcB,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res_lo,
  output logic [W-1:0] res_hi,
  output logic         zero,
  output logic         div0,
  output logic         busy
);
  localparam int CW = $clog2(W) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [3:0] r_op;
  logic [W-1:0] r_opnd, r_lo, r_hi, w_res;
  logic r_div0, w_acc, w_dz, w_multi;
  logic [W:0] w_sum, w_rem, w_diff;
  assign w_acc = in_valid & in_ready;
  assign w_dz = op == 4'b1001 && srcB == '0;
  assign w_multi = (op == 4'b1000 || op == 4'b1001) && !w_dz;
  assign w_sum = {1'b0, r_hi} + {1'b0, r_opnd};
  assign w_rem = {r_hi, r_lo[W-1]};
  assign w_diff = w_rem - {1'b0, r_opnd};
  assign in_ready = r_state == IDLE;
  assign busy = r_state != IDLE;
  assign out_valid = r_state == DONE;
  assign res_lo = r_lo;
  assign res_hi = r_hi;
  assign zero = r_lo == '0;
  assign div0 = r_div0;
  // single-cycle result from the live operands, registered at the accept edge
  always_comb
    w_res = op == 4'b0000 ? srcA & srcB :
            op == 4'b0001 ? srcA | srcB :
            op == 4'b0010 ? srcA + srcB :
            op == 4'b0100 ? srcA & ~srcB :
            op == 4'b0101 ? srcA | ~srcB :
            op == 4'b0110 ? srcA - srcB :
            op == 4'b0111 ? {{(W-1){1'b0}}, $signed(srcA) < $signed(srcB)} : '0;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  // next state: divide by zero skips CALC, multi-cycle ops run W steps
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_acc) w_next = w_multi ? CALC : DONE;
      CALC: if (r_cnt == CW'(1)) w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // operand latch, one shift-add / restoring shift-subtract step per CALC cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt <= '0;
      r_op <= '0;
      r_opnd <= '0;
      r_lo <= '0;
      r_hi <= '0;
      r_div0 <= 1'b0;
    end else if (w_acc) begin
      r_op <= op;
      r_div0 <= w_dz;
      r_cnt <= w_multi ? CW'(W) : '0;
      r_opnd <= op == 4'b1000 ? srcA : srcB;
      r_lo <= w_multi ? (op == 4'b1000 ? srcB : srcA) : w_dz ? '1 : w_res;
      r_hi <= w_dz ? srcA : '0;
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_op == 4'b1000) begin
        r_hi <= r_lo[0] ? w_sum[W:1] : {1'b0, r_hi[W-1:1]};
        r_lo <= {r_lo[0] ? w_sum[0] : r_hi[0], r_lo[W-1:1]};
      end else begin
        r_hi <= w_diff[W] ? w_rem[W-1:0] : w_diff[W-1:0];
        r_lo <= {r_lo[W-2:0], !w_diff[W]};
      end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed checks of seq_alu at W=32 and W=8 against an arithmetic model
module tb_seq_alu;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0, sel = 0;
  logic [3:0] op = 0;
  logic [31:0] srcA = 0, srcB = 0;
  logic ir32, ov32, z32, d32, b32, ir8, ov8, z8, d8, b8;
  logic [31:0] lo32, hi32;
  logic [7:0] lo8, hi8;
  logic t_ir, t_ov, t_z, t_d, t_b;
  logic [63:0] t_lo, t_hi;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  seq_alu #(.W(32)) u32 (.clk(clk), .reset(reset), .in_valid(in_valid & !sel), .in_ready(ir32),
    .op(op), .srcA(srcA), .srcB(srcB), .out_valid(ov32), .out_ready(out_ready),
    .res_lo(lo32), .res_hi(hi32), .zero(z32), .div0(d32), .busy(b32));
  seq_alu #(.W(8)) u8 (.clk(clk), .reset(reset), .in_valid(in_valid & sel), .in_ready(ir8),
    .op(op), .srcA(srcA[7:0]), .srcB(srcB[7:0]), .out_valid(ov8), .out_ready(out_ready),
    .res_lo(lo8), .res_hi(hi8), .zero(z8), .div0(d8), .busy(b8));
  assign t_ir = sel ? ir8 : ir32;
  assign t_ov = sel ? ov8 : ov32;
  assign t_z = sel ? z8 : z32;
  assign t_d = sel ? d8 : d32;
  assign t_b = sel ? b8 : b32;
  assign t_lo = sel ? {56'd0, lo8} : {32'd0, lo32};
  assign t_hi = sel ? {56'd0, hi8} : {32'd0, hi32};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s W=%0d got=%h expected=%h", tag, sel ? 8 : 32, got, exp);
    end
  endtask
  task automatic model(input int w, input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] lo, output logic [63:0] hi, output logic dz);
    logic [63:0] m, p;
    longint sa, sb;
    m = (64'd1 << w) - 1;
    sa = longint'(a);
    sb = longint'(b);
    if (a[w-1]) sa = sa - longint'(64'd1 << w);
    if (b[w-1]) sb = sb - longint'(64'd1 << w);
    hi = 0;
    dz = 0;
    p = a * b;
    case (o)
      4'd0: lo = a & b;
      4'd1: lo = a | b;
      4'd2: lo = (a + b) & m;
      4'd4: lo = a & ~b & m;
      4'd5: lo = (a | ~b) & m;
      4'd6: lo = (a - b) & m;
      4'd7: lo = sa < sb ? 1 : 0;
      4'd8: begin lo = p & m; hi = p >> w; end
      4'd9: if (b == 0) begin lo = m; hi = a; dz = 1; end else begin lo = a / b; hi = a % b; end
      default: lo = 0;
    endcase
  endtask
  task automatic reset_chk(input string tag);
    check({tag, "_ov"}, t_ov, 0);
    check({tag, "_lo"}, t_lo, 0);
    check({tag, "_hi"}, t_hi, 0);
    check({tag, "_zero"}, t_z, 1);
    check({tag, "_div0"}, t_d, 0);
    check({tag, "_ready"}, t_ir, 1);
    check({tag, "_busy"}, t_b, 0);
  endtask
  task automatic scramble(input logic v);
    in_valid = v;
    op = 4'($urandom);
    srcA = $urandom;
    srcB = $urandom;
  endtask
  task automatic run(input logic w8, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] ea, eb, elo, ehi;
    logic ed;
    int w, elat, lat;
    w = w8 ? 8 : 32;
    ea = w8 ? {56'd0, a[7:0]} : {32'd0, a};
    eb = w8 ? {56'd0, b[7:0]} : {32'd0, b};
    model(w, o, ea, eb, elo, ehi, ed);
    elat = (o == 4'd8 || (o == 4'd9 && eb != 0)) ? w + 1 : 1;
    @(negedge clk);
    sel = w8;
    in_valid = 1;
    op = o;
    srcA = a;
    srcB = b;
    #1 check("in_ready", t_ir, 1);
    @(posedge clk);
    #1 scramble(0);
    lat = 1;
    while (!t_ov && lat < 100) begin
      check("busy", t_b, 1);
      @(posedge clk);
      #1 scramble(1'($urandom));
      lat++;
    end
    check("latency", 64'(lat), 64'(elat));
    check("res_lo", t_lo, elo);
    check("res_hi", t_hi, ehi);
    check("zero", t_z, elo == 0);
    check("div0", t_d, ed);
    repeat (hold) begin
      @(posedge clk);
      #1 scramble(1'($urandom));
      check("hold_valid", t_ov, 1);
      check("hold_ready", t_ir, 0);
      check("hold_lo", t_lo, elo);
      check("hold_hi", t_hi, ehi);
    end
    @(negedge clk);
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    check("released_valid", t_ov, 0);
    check("released_ready", t_ir, 1);
  endtask
  initial begin
    #12 reset_chk("reset32");
    sel = 1;
    #1 reset_chk("reset8");
    @(negedge clk) reset = 0;
    for (int s = 0; s < 2; s++) begin
      run(s[0], 4'd2, 32'h7FFFFFFF, 32'd1, 0);
      run(s[0], 4'd6, 32'd5, 32'd5, 0);
      run(s[0], 4'd7, 32'hFFFFFFFF, 32'd1, 0);
      run(s[0], 4'd7, 32'd1, 32'hFFFFFFFF, 0);
      run(s[0], 4'd4, 32'hF0F0, 32'h00FF, 0);
      run(s[0], 4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      run(s[0], 4'd9, 32'd100, 32'd7, 0);
      run(s[0], 4'd9, 32'd9, 32'd0, 0);
      run(s[0], 4'd1, 32'h1234, 32'h8000_0001, 10);
      run(s[0], 4'd3, 32'hFFFF, 32'h1, 0);
    end
    @(negedge clk);
    sel = 0;
    in_valid = 1;
    op = 4'd8;
    srcA = 32'hDEADBEEF;
    srcB = 32'h12345678;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (11) @(posedge clk);
    #2 reset = 1;
    #1 reset_chk("midcalc");
    @(negedge clk) reset = 0;
    run(0, 4'd2, 32'd2, 32'd3, 0);
    for (int i = 0; i < 200; i++)
      run(1'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0 ? $urandom_range(0, 20) : $urandom,
          $urandom_range(0, 5) == 0 ? 0 : $urandom_range(0, 3) == 0 ? $urandom_range(1, 20) : $urandom,
          $urandom_range(0, 2));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
